// File: rtl/dbg_pkg.sv
// Shared definitions for the debug transfer sequencer: dbgIF command codes,
// SWD acknowledge values and the sequencer state encoding.
package dbg_pkg;

  localparam logic [3:0] CMD_RESET      = 4'd0;
  localparam logic [3:0] CMD_PINS_WRITE = 4'd1;
  localparam logic [3:0] CMD_TRANSACT   = 4'd2;
  localparam logic [3:0] CMD_SET_SWJ    = 4'd3;
  localparam logic [3:0] CMD_SET_SWD    = 4'd4;
  localparam logic [3:0] CMD_SET_JTAG   = 4'd5;
  localparam logic [3:0] CMD_SET_SWC    = 4'd6;
  localparam logic [3:0] CMD_SET_CLKDIV = 4'd7;
  localparam logic [3:0] CMD_SET_CFG    = 4'd8;
  localparam logic [3:0] CMD_WAIT       = 4'd9;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COMPLETE,
    ST_EVAL,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/dbg_xfer_seq.sv
// Single-request sequencer in front of dbgIF: issues go/done handshakes, retries
// WAIT acks, and (with XFER_MATCH_EN defined) retries value-match reads.
module dbg_xfer_seq
  import dbg_pkg::*;
#(
  parameter int RETRY_W       = 16,
  parameter int MATCH_RETRY_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_cmd,
  input  logic [1:0]               req_addr32,
  input  logic                     req_rnw,
  input  logic                     req_apndp,
  input  logic [31:0]              req_data,
  input  logic                     req_match,
  input  logic [31:0]              match_mask,
  input  logic [RETRY_W-1:0]       wait_retry,
  input  logic [MATCH_RETRY_W-1:0] match_retry,
  input  logic                     abort,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_ack,
  output logic [31:0]              rsp_data,
  output logic                     rsp_perr,
  output logic                     rsp_mismatch,
  output logic [RETRY_W-1:0]       rsp_retries,
  output logic [3:0]               dbg_command,
  output logic [1:0]               dbg_addr32,
  output logic                     dbg_rnw,
  output logic                     dbg_apndp,
  output logic [31:0]              dbg_dwrite,
  output logic                     dbg_go,
  input  logic                     dbg_done,
  input  logic [2:0]               dbg_ack,
  input  logic [31:0]              dbg_dread,
  input  logic                     dbg_perr
);

  seq_state_e         state;
  logic [RETRY_W-1:0] wait_cnt;
  logic               abort_seen;
  logic [2:0]         ack_q;
  logic [31:0]        dread_q;
  logic               perr_q;
  logic               wait_retry_ok;

  assign req_ready     = (state == ST_IDLE) && dbg_done && !rst;
  assign wait_retry_ok = (dbg_command == CMD_TRANSACT) && (ack_q == ACK_WAIT) &&
                         !perr_q && (wait_cnt < wait_retry);

`ifdef XFER_MATCH_EN
  logic [MATCH_RETRY_W-1:0] match_cnt;
  logic                     match_q;
  logic                     mismatch_q;
  logic                     match_fail;

  // dbg_dwrite carries the match value for match reads
  assign match_fail   = match_q && dbg_rnw && (ack_q == ACK_OK) && !perr_q &&
                        (((dread_q ^ dbg_dwrite) & match_mask) != 32'd0);
  assign rsp_mismatch = mismatch_q;
`else
  logic unused_match;
  assign unused_match = ^{req_match, match_mask, match_retry};
  assign rsp_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      abort_seen  <= 1'b0;
      ack_q       <= 3'd0;
      dread_q     <= 32'd0;
      perr_q      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_ack     <= 3'd0;
      rsp_data    <= 32'd0;
      rsp_perr    <= 1'b0;
      rsp_retries <= '0;
      dbg_command <= 4'd0;
      dbg_addr32  <= 2'd0;
      dbg_rnw     <= 1'b0;
      dbg_apndp   <= 1'b0;
      dbg_dwrite  <= 32'd0;
      dbg_go      <= 1'b0;
`ifdef XFER_MATCH_EN
      match_cnt   <= '0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
`endif
    end else begin
      if (state != ST_IDLE && abort) abort_seen <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            dbg_command <= req_cmd;
            dbg_addr32  <= req_addr32;
            dbg_rnw     <= req_rnw;
            dbg_apndp   <= req_apndp;
            dbg_dwrite  <= req_data;
            dbg_go      <= 1'b1;
            wait_cnt    <= '0;
            abort_seen  <= 1'b0;
`ifdef XFER_MATCH_EN
            match_cnt   <= '0;
            match_q     <= req_match;
`endif
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!dbg_done) begin
            dbg_go <= 1'b0;
            state  <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          if (dbg_done) begin
            ack_q   <= dbg_ack;
            dread_q <= dbg_dread;
            perr_q  <= dbg_perr;
            state   <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // Response fields load only here so they hold the previous result meanwhile
          rsp_ack     <= ack_q;
          rsp_data    <= dread_q;
          rsp_perr    <= perr_q;
          rsp_retries <= wait_cnt;
`ifdef XFER_MATCH_EN
          mismatch_q  <= 1'b0;
`endif
          if (abort || abort_seen) begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (wait_retry_ok) begin
            rsp_ack     <= rsp_ack;
            rsp_data    <= rsp_data;
            rsp_perr    <= rsp_perr;
            rsp_retries <= rsp_retries;
`ifdef XFER_MATCH_EN
            mismatch_q  <= mismatch_q;
`endif
            wait_cnt    <= wait_cnt + 1'b1;
            dbg_go      <= 1'b1;
            state       <= ST_ISSUE;
`ifdef XFER_MATCH_EN
          end else if (match_fail && (match_cnt < match_retry)) begin
            rsp_ack     <= rsp_ack;
            rsp_data    <= rsp_data;
            rsp_perr    <= rsp_perr;
            rsp_retries <= rsp_retries;
            mismatch_q  <= mismatch_q;
            match_cnt   <= match_cnt + 1'b1;
            wait_cnt    <= '0;
            dbg_go      <= 1'b1;
            state       <= ST_ISSUE;
          end else if (match_fail) begin
            mismatch_q <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
`endif
          end else begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_xfer_seq.sv
// Bench for dbg_xfer_seq: behavioural dbgIF driven by per-operation ack scripts,
// a loop-based reference for the expected response, and a per-cycle compare process.
module tb_dbg_xfer_seq;
  import dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_cmd = 4'd0;
  logic [1:0]  req_addr32 = 2'd0;
  logic        req_rnw = 1'b0, req_apndp = 1'b0, req_match = 1'b0;
  logic [31:0] req_data = 32'd0, match_mask = 32'd0;
  logic [15:0] wait_retry = 16'd0, match_retry = 16'd0;
  logic        abort, abort_m = 1'b0, abort_i = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_data;
  logic        rsp_perr, rsp_mismatch;
  logic [15:0] rsp_retries;
  logic [3:0]  dbg_command;
  logic [1:0]  dbg_addr32;
  logic        dbg_rnw, dbg_apndp, dbg_go;
  logic [31:0] dbg_dwrite;
  logic        dbg_done = 1'b1;
  logic [2:0]  dbg_ack = 3'd0;
  logic [31:0] dbg_dread = 32'd0;
  logic        dbg_perr = 1'b0;

  assign abort = abort_m | abort_i;

  dbg_xfer_seq #(.RETRY_W(16), .MATCH_RETRY_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr32(req_addr32), .req_rnw(req_rnw), .req_apndp(req_apndp),
    .req_data(req_data), .req_match(req_match), .match_mask(match_mask),
    .wait_retry(wait_retry), .match_retry(match_retry), .abort(abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
    .rsp_data(rsp_data), .rsp_perr(rsp_perr), .rsp_mismatch(rsp_mismatch),
    .rsp_retries(rsp_retries), .dbg_command(dbg_command), .dbg_addr32(dbg_addr32),
    .dbg_rnw(dbg_rnw), .dbg_apndp(dbg_apndp), .dbg_dwrite(dbg_dwrite),
    .dbg_go(dbg_go), .dbg_done(dbg_done), .dbg_ack(dbg_ack),
    .dbg_dread(dbg_dread), .dbg_perr(dbg_perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ops;
    logic [2:0]  ack;
    logic [31:0] data;
    logic        perr;
    logic        mism;
    logic [15:0] retries;
  } exp_t;

  // Per-operation dbgIF behaviour; operations past the end repeat the last entry
  logic [2:0]  ack_scr  [8];
  logic [31:0] dread_scr[8];
  logic        perr_scr [8];
  int          abort_op = -1;
  int          nops = 0;
  int          lat = 0;
  int          cur = 0;
  int          n_vec = 0, n_err = 0;
  bit          chk_en = 1'b0;
  exp_t        exp_r;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  // dbgIF stand-in: takes go while idle, stays busy a random time, then presents results
  always @(negedge clk) begin
    abort_m = 1'b0;
    if (rst) begin
      dbg_done = 1'b1;
    end else if (dbg_done && dbg_go) begin
      cur      = (nops > 7) ? 7 : nops;
      dbg_done = 1'b0;
      dbg_ack  = 3'($urandom);
      dbg_dread = $urandom;
      dbg_perr = 1'($urandom);
      lat      = $urandom_range(0, 3);
      if (nops == abort_op) abort_m = 1'b1;
      nops++;
    end else if (!dbg_done) begin
      if (lat == 0) begin
        dbg_done  = 1'b1;
        dbg_ack   = ack_scr[cur];
        dbg_dread = dread_scr[cur];
        dbg_perr  = perr_scr[cur];
      end else lat--;
    end
  end

  // Reference: walk the scripted operations and apply the retry/abort/match rules
  function automatic exp_t ref_model(logic [3:0] cmd, logic rnw, logic mt, logic [31:0] data,
                                     logic [31:0] mask, int wr, int mr, int aop);
    exp_t r;
    int w = 0, m = 0, k;
    r = '{0, 3'd0, 32'd0, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 4000; i++) begin
      k = (i > 7) ? 7 : i;
      r.ops = i + 1; r.ack = ack_scr[k]; r.data = dread_scr[k]; r.perr = perr_scr[k];
      r.retries = 16'(w);
      if (i == aop) return r;
      if (cmd == CMD_TRANSACT && r.ack == ACK_WAIT && !r.perr && w < wr) begin
        w++;
        continue;
      end
`ifdef XFER_MATCH_EN
      if (mt && rnw && r.ack == ACK_OK && !r.perr && ((r.data ^ data) & mask) != 0) begin
        if (m < mr) begin m++; w = 0; continue; end
        r.mism = 1'b1;
        return r;
      end
`else
      if (mt && rnw && (data & mask) != 0 && m < 0 && mr < 0) return r;
`endif
      return r;
    end
    return r;
  endfunction

  // Compare process: while a response is presented it must equal the reference
  always @(negedge clk) begin
    #1;
    if (!rst && chk_en) begin
      if (rsp_valid) begin
        check("rsp_ack", 32'(rsp_ack), 32'(exp_r.ack));
        check("rsp_data", rsp_data, exp_r.data);
        check("rsp_perr", 32'(rsp_perr), 32'(exp_r.perr));
        check("rsp_mismatch", 32'(rsp_mismatch), 32'(exp_r.mism));
        check("rsp_retries", 32'(rsp_retries), 32'(exp_r.retries));
        check("go_pulses", 32'(nops), 32'(exp_r.ops));
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
      if (dbg_go) begin
        check("dbg_command", 32'(dbg_command), 32'(req_cmd));
        check("dbg_dwrite", dbg_dwrite, req_data);
        check("dbg_addr32", 32'(dbg_addr32), 32'(req_addr32));
      end
    end
  end

  task automatic fill(logic [2:0] a, logic [31:0] d, logic p);
    for (int i = 0; i < 8; i++) begin ack_scr[i] = a; dread_scr[i] = d; perr_scr[i] = p; end
  endtask

  task automatic run_req(logic [3:0] cmd, logic ap, logic rnw, logic [31:0] data, logic mt,
                         logic [31:0] mask, int wr, int mr, int aop, int hold);
    bit ok;
    req_cmd = cmd; req_apndp = ap; req_rnw = rnw; req_data = data; req_match = mt;
    req_addr32 = 2'($urandom); match_mask = mask;
    wait_retry = 16'(wr); match_retry = 16'(mr); abort_op = aop;
    exp_r = ref_model(cmd, rnw, mt, data, mask, wr, mr, aop);
    nops = 0;
    chk_en = 1'b1;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); #2;
      if (req_ready) begin @(posedge clk); #1 req_valid = 1'b0; ok = 1'b1; end
    end
    req_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk); #2;
      rsp_ready = (c >= hold) && ($urandom_range(0, 2) != 0);
      if (rsp_valid && rsp_ready) begin @(posedge clk); #1 rsp_ready = 1'b0; ok = 1'b1; end
    end
    rsp_ready = 1'b0;
    if (!ok) check("response_timeout", 32'd1, 32'd0);
    abort_op = -1;
  endtask

  initial begin
    fill(ACK_OK, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_dbg_go", 32'(dbg_go), 32'd0);
    check("reset_rsp_ack", 32'(rsp_ack), 32'd0);
    check("reset_rsp_retries", 32'(rsp_retries), 32'd0);
    check("reset_dbg_dwrite", dbg_dwrite, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    fill(ACK_OK, 32'habcdef12, 1'b0);
    run_req(CMD_TRANSACT, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 0, 0, -1, 0);
    check("dp_read_ops", 32'(nops), 32'd1);
    check("dp_read_data", rsp_data, 32'habcdef12);
    check("dp_read_ack", 32'(rsp_ack), 32'(ACK_OK));

    fill(ACK_OK, 32'h55aa0011, 1'b0);
    ack_scr[0] = ACK_WAIT; ack_scr[1] = ACK_WAIT;
    run_req(CMD_TRANSACT, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 5, 0, -1, 0);
    check("ap_wait2_ops", 32'(nops), 32'd3);
    check("ap_wait2_retries", 32'(rsp_retries), 32'd2);
    check("ap_wait2_ack", 32'(rsp_ack), 32'(ACK_OK));

    fill(ACK_WAIT, 32'd7, 1'b0);
    run_req(CMD_TRANSACT, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 3, 0, -1, 0);
    check("wait_sat_ops", 32'(nops), 32'd4);
    check("wait_sat_retries", 32'(rsp_retries), 32'd3);
    check("wait_sat_ack", 32'(rsp_ack), 32'(ACK_WAIT));

    run_req(CMD_TRANSACT, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 100, 0, 1, 0);
    check("abort_ops", 32'(nops), 32'd2);
    check("abort_retries", 32'(rsp_retries), 32'd1);

    fill(ACK_WAIT, 32'd9, 1'b1);
    run_req(CMD_TRANSACT, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 5, 0, -1, 0);
    check("perr_ops", 32'(nops), 32'd1);
    check("perr_flag", 32'(rsp_perr), 32'd1);

    fill(ACK_WAIT, 32'd0, 1'b0);
    run_req(CMD_RESET, 1'b0, 1'b0, 32'h12345678, 1'b0, 32'd0, 5, 0, -1, 6);
    check("reset_cmd_ops", 32'(nops), 32'd1);

`ifdef XFER_MATCH_EN
    fill(ACK_OK, 32'h1, 1'b0);
    dread_scr[0] = 32'h0; dread_scr[1] = 32'h0;
    run_req(CMD_TRANSACT, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 0, 5, -1, 0);
    check("match_ok_ops", 32'(nops), 32'd3);
    check("match_ok_mism", 32'(rsp_mismatch), 32'd0);
    fill(ACK_OK, 32'h0, 1'b0);
    run_req(CMD_TRANSACT, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 0, 2, -1, 0);
    check("match_fail_ops", 32'(nops), 32'd3);
    check("match_fail_mism", 32'(rsp_mismatch), 32'd1);
`endif

    for (int t = 0; t < 80; t++) begin
      logic [3:0] cmd;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: ack_scr[i] = ACK_OK;
          1, 2: ack_scr[i] = ACK_WAIT;
          default: ack_scr[i] = ($urandom_range(0, 1) != 0) ? ACK_FAULT : 3'($urandom);
        endcase
        dread_scr[i] = $urandom & 32'h3;
        perr_scr[i] = ($urandom_range(0, 9) == 0);
      end
      cmd = ($urandom_range(0, 3) != 0) ? CMD_TRANSACT : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        abort_i = 1'b1; @(posedge clk); #1 abort_i = 1'b0;
      end
      run_req(cmd, 1'($urandom), 1'($urandom), $urandom & 32'h3, 1'($urandom), $urandom & 32'h3,
              $urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, $urandom_range(0, 3));
    end

    // Reset in the middle of an operation must drop go and return to idle
    fill(ACK_WAIT, 32'd0, 1'b0);
    chk_en = 1'b0;
    req_cmd = CMD_TRANSACT; wait_retry = 16'd50; req_valid = 1'b1;
    @(negedge clk); @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midop_reset_go", 32'(dbg_go), 32'd0);
    check("midop_reset_valid", 32'(rsp_valid), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    check("midop_reset_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbg_xfer_seq.md
Name: dbg_xfer_seq

Overview:
- Transfer sequencer directly upstream of dbgIF. Accepts single debug-port requests on a valid/ready interface and drives dbgIF's go/done handshake.
- Retries SWD WAIT acknowledges up to a programmable limit and returns one response per request on a valid/ready interface.
- Decouples the host-protocol layer (CMSIS-DAP style command decoder) from dbgIF timing.

Parameters:
- RETRY_W, 16, width of the WAIT-retry limit and retry counter
- MATCH_RETRY_W, 16, width of the value-match retry limit (used only with XFER_MATCH_EN)

Ports:
- clk  in  1  system clock, shared with dbgIF
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_cmd  in  4  dbgIF command code
- req_addr32  in  2  address bits 3:2
- req_rnw  in  1  1 = read, 0 = write
- req_apndp  in  1  1 = AP, 0 = DP
- req_data  in  32  write data or parameter; match value for match reads
- req_match  in  1  value-match read (ignored unless XFER_MATCH_EN)
- match_mask  in  32  mask for value match
- wait_retry  in  RETRY_W  maximum WAIT retries; 0 means no retry
- match_retry  in  MATCH_RETRY_W  maximum match retries
- abort  in  1  stop retrying after the current dbgIF operation
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_ack  out  3  final ack from dbgIF
- rsp_data  out  32  final dread
- rsp_perr  out  1  final perr
- rsp_mismatch  out  1  match retries exhausted without a match
- rsp_retries  out  RETRY_W  WAIT retries consumed
- dbg_command  out  4  to dbgIF command
- dbg_addr32  out  2  to dbgIF addr32
- dbg_rnw  out  1  to dbgIF rnw
- dbg_apndp  out  1  to dbgIF apndp
- dbg_dwrite  out  32  to dbgIF dwrite
- dbg_go  out  1  to dbgIF go
- dbg_done  in  1  from dbgIF done (high when idle)
- dbg_ack  in  3  from dbgIF ack
- dbg_dread  in  32  from dbgIF dread
- dbg_perr  in  1  from dbgIF perr

Behaviour:
- Reset values (rst high at a clk edge): state IDLE; req_ready=0, rsp_valid=0, dbg_go=0; rsp_ack, rsp_data, rsp_perr, rsp_mismatch, rsp_retries = 0; dbg_* data outputs = 0; all counters = 0.
- IDLE:
  - req_ready = 1 only while in IDLE and dbg_done = 1.
  - On req_valid & req_ready, register every req_* field into the dbg_* outputs, clear both counters, then go to ISSUE.
- ISSUE: dbg_go = 1. Hold until dbg_done is sampled 0, then go to COMPLETE with dbg_go = 0 from the next cycle.
- COMPLETE: dbg_go = 0. Hold until dbg_done is sampled 1, then register dbg_ack, dbg_dread and dbg_perr; go to EVAL.
- EVAL (one cycle), first matching rule wins:
  1. abort is high, or abort was seen since the request was accepted (sticky flag) -> RESP.
  2. dbg_command == CMD_TRANSACT, ack == 3'b010, perr == 0, and retry count < wait_retry -> increment the count, go to ISSUE.
  3. Match rule (XFER_MATCH_EN only) -> see Optional Feature.
  4. Otherwise -> RESP.
- RESP:
  - rsp_valid = 1; all rsp_* outputs stable while rsp_valid & !rsp_ready.
  - On rsp_ready, go to IDLE; rsp_* keep their values until the next response.
- Non-TRANSACT commands are issued exactly once and never retried.
- Retry count saturates at wait_retry and never wraps.
- wait_retry = 0 gives exactly one dbgIF operation.
- abort:
  - Never truncates a dbgIF handshake in progress.
  - Abort seen in IDLE with no request pending is ignored; the sticky flag clears on request accept.
- Reset mid-operation: the next edge forces IDLE and drops dbg_go. dbgIF is reset by the same rst.
- Latency: request accept to dbg_go high is 1 cycle; dbg_done rising to rsp_valid is 2 cycles (COMPLETE register, then EVAL) when no retry occurs.

Optional Feature:
- Macro: XFER_MATCH_EN.
- With the macro defined, EVAL gains the match rule:
  - Applies when req_match = 1, rnw = 1, ack == 3'b001, perr == 0, and (dread & match_mask) != (req_data & match_mask).
  - If match count < match_retry: increment the match count, clear the WAIT count, go to ISSUE.
  - Otherwise: set rsp_mismatch = 1 and go to RESP.
- Without the macro: req_match, match_mask and match_retry are unused; rsp_mismatch is tied to 0; no match counter is instantiated.

Decomposition:
- Package dbg_pkg holds:
  - CMD_* command codes, identical to dbgIF's values (CMD_TRANSACT, CMD_RESET, etc.);
  - ACK_OK = 3'b001, ACK_WAIT = 3'b010, ACK_FAULT = 3'b100;
  - the sequencer state enum.
- No sub-module: a single FSM plus counters. A behavioural dbgIF model lives only in the bench.

Test Plan:
- DP read with model returning ack 001, dread 32'habcdef12 -> one go pulse; rsp_ack = 001, rsp_data = abcdef12, rsp_retries = 0.
- AP read with model returning WAIT twice then OK, wait_retry = 5 -> three go pulses; rsp_ack = 001, rsp_retries = 2.
- WAIT always, wait_retry = 3 -> four go pulses; rsp_ack = 010, rsp_retries = 3.
- WAIT always, wait_retry = 100, abort pulsed during the second operation -> exactly two go pulses; rsp_ack = 010, rsp_retries = 1.
- Parity-error read (perr = 1, ack 010) -> no retry; rsp_perr = 1. Then CMD_RESET -> single issue, rsp_valid held until rsp_ready, no new request accepted meanwhile.
- XFER_MATCH_EN: req_data = 0x1, mask = 0x1, dread alternating 0x0, 0x0, 0x1 -> three issues, rsp_mismatch = 0. With dread stuck at 0x0 and match_retry = 2 -> three issues, rsp_mismatch = 1.
